// File: rtl/ysyx_23060111_wbu_if.sv
// Writeback unit bus: EXU handshake, LSU read return, register/CSR file write ports,
// redirect and commit. The slave modport is the WBU side.
interface ysyx_23060111_wbu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  // Valid/ready: a transfer happens on a rising clk edge where both valid and ready
  // are high. The source holds its payload stable from the rise of valid until that edge.
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_rd_wen;
  logic [DATA_WIDTH-1:0] in_result;
  logic                  in_is_load;
  logic                  in_csr_wen;
  logic [1:0]            in_csr_waddr;
  logic [DATA_WIDTH-1:0] in_csr_wdata;
  logic                  in_ecall;
  logic                  in_mret;
  logic [DATA_WIDTH-1:0] cur_mstatus;
  logic [DATA_WIDTH-1:0] cur_mtvec;
  logic [DATA_WIDTH-1:0] cur_mepc;
  logic                  lsu_rvalid;
  logic [DATA_WIDTH-1:0] lsu_rdata;
  logic                  lsu_rready;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  csr_wen;
  logic [1:0]            csr_waddr;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic                  csr_mepc_wen;
  logic [DATA_WIDTH-1:0] csr_mepc_wdata;
  logic                  csr_mcause_wen;
  logic [DATA_WIDTH-1:0] csr_mcause_wdata;
  logic                  csrr_mstatus_wen;
  logic [DATA_WIDTH-1:0] csr_mstatus_wdata;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  commit_valid;
  logic [DATA_WIDTH-1:0] commit_pc;
  logic [1:0]            dbg_state;

  modport slave (
    input  in_valid, in_pc, in_rd, in_rd_wen, in_result, in_is_load,
           in_csr_wen, in_csr_waddr, in_csr_wdata, in_ecall, in_mret,
           cur_mstatus, cur_mtvec, cur_mepc, lsu_rvalid, lsu_rdata,
    output in_ready, lsu_rready, wen, waddr, wdata, csr_wen, csr_waddr, csr_wdata,
           csr_mepc_wen, csr_mepc_wdata, csr_mcause_wen, csr_mcause_wdata,
           csrr_mstatus_wen, csr_mstatus_wdata, redirect_valid, redirect_pc,
           commit_valid, commit_pc, dbg_state
  );

  modport master (
    output in_valid, in_pc, in_rd, in_rd_wen, in_result, in_is_load,
           in_csr_wen, in_csr_waddr, in_csr_wdata, in_ecall, in_mret,
           cur_mstatus, cur_mtvec, cur_mepc, lsu_rvalid, lsu_rdata,
    input  in_ready, lsu_rready, wen, waddr, wdata, csr_wen, csr_waddr, csr_wdata,
           csr_mepc_wen, csr_mepc_wdata, csr_mcause_wen, csr_mcause_wdata,
           csrr_mstatus_wen, csr_mstatus_wdata, redirect_valid, redirect_pc,
           commit_valid, commit_pc, dbg_state
  );
endinterface

// File: rtl/ysyx_23060111_wbu.sv
// Writeback unit: captures one retiring instruction, optionally waits for load data,
// then commits GPR/CSR/trap writes and any PC redirect in a single COMMIT cycle.
module ysyx_23060111_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  ysyx_23060111_wbu_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LD = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  rd_wen_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  is_load_q;
  logic                  csr_wen_q;
  logic [1:0]            csr_waddr_q;
  logic [DATA_WIDTH-1:0] csr_wdata_q;
  logic                  ecall_q;
  logic                  mret_q;
  logic [DATA_WIDTH-1:0] ld_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      rd_q        <= '0;
      rd_wen_q    <= 1'b0;
      result_q    <= '0;
      is_load_q   <= 1'b0;
      csr_wen_q   <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      ecall_q     <= 1'b0;
      mret_q      <= 1'b0;
      ld_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            pc_q        <= bus.in_pc;
            rd_q        <= bus.in_rd;
            rd_wen_q    <= bus.in_rd_wen;
            result_q    <= bus.in_result;
            is_load_q   <= bus.in_is_load;
            csr_wen_q   <= bus.in_csr_wen;
            csr_waddr_q <= bus.in_csr_waddr;
            csr_wdata_q <= bus.in_csr_wdata;
            ecall_q     <= bus.in_ecall;
            mret_q      <= bus.in_mret;
            ld_data_q   <= '0;
            state_q     <= (bus.in_is_load && bus.in_rd_wen) ? WAIT_LD : COMMIT;
          end
        end
        WAIT_LD: begin
          if (bus.lsu_rvalid) begin
            ld_data_q <= bus.lsu_rdata;
            state_q   <= COMMIT;
          end
        end
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic in_commit;
  logic do_ecall;
  logic do_mret;
  logic [DATA_WIDTH-1:0] mstatus_next;

  assign in_commit = (state_q == COMMIT);
  // ecall takes priority; a simultaneous mret is dropped.
  assign do_ecall  = in_commit && ecall_q;
  assign do_mret   = in_commit && mret_q && !ecall_q;

  always_comb begin
    mstatus_next = '0;
    if (do_ecall) begin
      mstatus_next        = bus.cur_mstatus;
      mstatus_next[7]     = bus.cur_mstatus[3];
      mstatus_next[3]     = 1'b0;
      mstatus_next[12:11] = 2'b11;
    end else if (do_mret) begin
      mstatus_next        = bus.cur_mstatus;
      mstatus_next[3]     = bus.cur_mstatus[7];
      mstatus_next[7]     = 1'b1;
      mstatus_next[12:11] = 2'b00;
    end
  end

  // State is forced to IDLE by reset, so every COMMIT-gated output is 0 while rst_n is low.
  assign bus.in_ready          = rst_n && (state_q == IDLE);
  assign bus.lsu_rready        = (state_q == WAIT_LD);
  assign bus.dbg_state         = state_q;

  assign bus.wen               = in_commit && rd_wen_q && (rd_q != '0);
  assign bus.waddr             = in_commit ? rd_q : '0;
  assign bus.wdata             = in_commit ? (is_load_q ? ld_data_q : result_q) : '0;

  assign bus.csr_wen           = in_commit && csr_wen_q && !ecall_q && !mret_q;
  assign bus.csr_waddr         = in_commit ? csr_waddr_q : '0;
  assign bus.csr_wdata         = in_commit ? csr_wdata_q : '0;

  assign bus.csr_mepc_wen      = do_ecall;
  assign bus.csr_mepc_wdata    = do_ecall ? pc_q : '0;
  assign bus.csr_mcause_wen    = do_ecall;
  assign bus.csr_mcause_wdata  = do_ecall ? DATA_WIDTH'(11) : '0;
  assign bus.csrr_mstatus_wen  = do_ecall || do_mret;
  assign bus.csr_mstatus_wdata = mstatus_next;

  assign bus.redirect_valid    = do_ecall || do_mret;
  assign bus.redirect_pc       = do_ecall ? bus.cur_mtvec : (do_mret ? bus.cur_mepc : '0);

  assign bus.commit_valid      = in_commit;
  assign bus.commit_pc         = in_commit ? pc_q : '0;
endmodule

// File: tb/tb_ysyx_23060111_wbu.sv
// Directed bench for the writeback unit: ALU, load, ecall, mret, rd=0, csrw and reset
// during a pending load, each checked against hand-computed values.
module tb_ysyx_23060111_wbu;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_COMM = 2'd2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ysyx_23060111_wbu_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  ysyx_23060111_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.in_valid     = 1'b0;
    bus.in_pc        = '0;
    bus.in_rd        = '0;
    bus.in_rd_wen    = 1'b0;
    bus.in_result    = '0;
    bus.in_is_load   = 1'b0;
    bus.in_csr_wen   = 1'b0;
    bus.in_csr_waddr = '0;
    bus.in_csr_wdata = '0;
    bus.in_ecall     = 1'b0;
    bus.in_mret      = 1'b0;
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present an instruction in IDLE, let the edge accept it, then drop valid
  task automatic accept(input logic [31:0] pc, input logic [4:0] rd, input logic rd_wen,
                        input logic [31:0] result, input logic is_load, input logic csr_wen,
                        input logic [1:0] csr_idx, input logic [31:0] csr_data,
                        input logic ecall, input logic mret);
    bus.in_valid     = 1'b1;
    bus.in_pc        = pc;
    bus.in_rd        = rd;
    bus.in_rd_wen    = rd_wen;
    bus.in_result    = result;
    bus.in_is_load   = is_load;
    bus.in_csr_wen   = csr_wen;
    bus.in_csr_waddr = csr_idx;
    bus.in_csr_wdata = csr_data;
    bus.in_ecall     = ecall;
    bus.in_mret      = mret;
    @(negedge clk);
    chk("accept_in_ready", bus.in_ready, 1'b1);
    tick();
    clear_in();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_in();
    bus.cur_mstatus = '0;
    bus.cur_mtvec   = '0;
    bus.cur_mepc    = '0;
    bus.lsu_rvalid  = 1'b0;
    bus.lsu_rdata   = '0;

    // reset state
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_state", bus.dbg_state, S_IDLE);
    chk("rst_wen", bus.wen, 1'b0);
    chk("rst_commit", bus.commit_valid, 1'b0);
    chk("rst_lsu_rready", bus.lsu_rready, 1'b0);
    chk("rst_redirect", bus.redirect_valid, 1'b0);
    chk("rst_wdata", bus.wdata, 32'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1'b1);

    // stray lsu_rvalid in IDLE is ignored
    bus.lsu_rvalid = 1'b1;
    bus.lsu_rdata  = 32'hBAD0BAD0;
    tick();
    bus.lsu_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_rvalid_state", bus.dbg_state, S_IDLE);
    chk("stray_rvalid_lsu_rready", bus.lsu_rready, 1'b0);
    tick();

    // ALU op: rd=5 result=0x1234
    accept(32'h8000_0000, 5'd5, 1'b1, 32'h1234, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("alu_state", bus.dbg_state, S_COMM);
    chk("alu_wen", bus.wen, 1'b1);
    chk("alu_waddr", bus.waddr, 32'd5);
    chk("alu_wdata", bus.wdata, 32'h1234);
    chk("alu_commit", bus.commit_valid, 1'b1);
    chk("alu_commit_pc", bus.commit_pc, 32'h8000_0000);
    chk("alu_in_ready_commit", bus.in_ready, 1'b0);
    chk("alu_csr_wen", bus.csr_wen, 1'b0);
    chk("alu_mepc_wen", bus.csr_mepc_wen, 1'b0);
    chk("alu_redirect", bus.redirect_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("alu_in_ready_after", bus.in_ready, 1'b1);
    chk("alu_commit_after", bus.commit_valid, 1'b0);
    chk("alu_wen_after", bus.wen, 1'b0);
    tick();

    // load rd=10, data three cycles after accept
    accept(32'h8000_0004, 5'd10, 1'b1, 32'h5555_5555, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ld_state_wait", bus.dbg_state, S_WAIT);
    chk("ld_rready_w1", bus.lsu_rready, 1'b1);
    chk("ld_wen_w1", bus.wen, 1'b0);
    chk("ld_commit_w1", bus.commit_valid, 1'b0);
    chk("ld_in_ready_w1", bus.in_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("ld_rready_w2", bus.lsu_rready, 1'b1);
    tick();
    bus.lsu_rvalid = 1'b1;
    bus.lsu_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ld_rready_w3", bus.lsu_rready, 1'b1);
    chk("ld_wen_w3", bus.wen, 1'b0);
    tick();
    bus.lsu_rvalid = 1'b0;
    bus.lsu_rdata  = '0;
    @(negedge clk);
    chk("ld_state_commit", bus.dbg_state, S_COMM);
    chk("ld_wen", bus.wen, 1'b1);
    chk("ld_waddr", bus.waddr, 32'd10);
    chk("ld_wdata", bus.wdata, 32'hDEAD_BEEF);
    chk("ld_commit_pc", bus.commit_pc, 32'h8000_0004);
    chk("ld_rready_commit", bus.lsu_rready, 1'b0);
    tick();

    // load without rd_wen skips the wait
    accept(32'h8000_0008, 5'd3, 1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ldnw_state", bus.dbg_state, S_COMM);
    chk("ldnw_wen", bus.wen, 1'b0);
    tick();

    // ecall with a (suppressed) CSR write request
    bus.cur_mstatus = 32'h0000_0008;
    bus.cur_mtvec   = 32'h8000_0400;
    bus.cur_mepc    = 32'h1111_1111;
    accept(32'h8000_0100, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 2'd1, 32'hABCD, 1'b1, 1'b0);
    @(negedge clk);
    chk("ecall_mepc_wen", bus.csr_mepc_wen, 1'b1);
    chk("ecall_mepc", bus.csr_mepc_wdata, 32'h8000_0100);
    chk("ecall_mcause_wen", bus.csr_mcause_wen, 1'b1);
    chk("ecall_mcause", bus.csr_mcause_wdata, 32'd11);
    chk("ecall_mstatus_wen", bus.csrr_mstatus_wen, 1'b1);
    chk("ecall_mstatus", bus.csr_mstatus_wdata, 32'h0000_1880);
    chk("ecall_redirect", bus.redirect_valid, 1'b1);
    chk("ecall_redirect_pc", bus.redirect_pc, 32'h8000_0400);
    chk("ecall_csr_wen", bus.csr_wen, 1'b0);
    chk("ecall_wen", bus.wen, 1'b0);
    tick();
    @(negedge clk);
    chk("ecall_redirect_after", bus.redirect_valid, 1'b0);
    chk("ecall_mepc_wen_after", bus.csr_mepc_wen, 1'b0);
    tick();

    // mret
    bus.cur_mstatus = 32'h0000_1880;
    bus.cur_mepc    = 32'h8000_0104;
    accept(32'h8000_0400, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("mret_mstatus_wen", bus.csrr_mstatus_wen, 1'b1);
    chk("mret_mstatus", bus.csr_mstatus_wdata, 32'h0000_0088);
    chk("mret_redirect", bus.redirect_valid, 1'b1);
    chk("mret_redirect_pc", bus.redirect_pc, 32'h8000_0104);
    chk("mret_mepc_wen", bus.csr_mepc_wen, 1'b0);
    chk("mret_mcause_wen", bus.csr_mcause_wen, 1'b0);
    chk("mret_wen", bus.wen, 1'b0);
    tick();

    // ecall and mret together: ecall wins, GPR write honoured
    bus.cur_mstatus = 32'h0000_0000;
    bus.cur_mtvec   = 32'h8000_0800;
    bus.cur_mepc    = 32'h8000_0ABC;
    accept(32'h8000_0200, 5'd7, 1'b1, 32'h77, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    chk("both_redirect_pc", bus.redirect_pc, 32'h8000_0800);
    chk("both_mcause_wen", bus.csr_mcause_wen, 1'b1);
    chk("both_mstatus", bus.csr_mstatus_wdata, 32'h0000_1800);
    chk("both_wen", bus.wen, 1'b1);
    chk("both_wdata", bus.wdata, 32'h77);
    tick();

    // rd=0 never writes
    accept(32'h8000_0010, 5'd0, 1'b1, 32'hFFFF, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rd0_commit", bus.commit_valid, 1'b1);
    chk("rd0_wen", bus.wen, 1'b0);
    tick();

    // csrw mtvec
    accept(32'h8000_0014, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 2'd3, 32'h8000_0400, 1'b0, 1'b0);
    @(negedge clk);
    chk("csrw_wen", bus.csr_wen, 1'b1);
    chk("csrw_waddr", bus.csr_waddr, 32'd3);
    chk("csrw_wdata", bus.csr_wdata, 32'h8000_0400);
    chk("csrw_mstatus_wen", bus.csrr_mstatus_wen, 1'b0);
    chk("csrw_redirect", bus.redirect_valid, 1'b0);
    tick();

    // reset during WAIT_LD drops the load
    accept(32'h8000_0018, 5'd9, 1'b1, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rstld_state_wait", bus.dbg_state, S_WAIT);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstld_state_async", bus.dbg_state, S_IDLE);
    chk("rstld_rready", bus.lsu_rready, 1'b0);
    chk("rstld_in_ready", bus.in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    bus.lsu_rvalid = 1'b1;
    bus.lsu_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rstld_in_ready_rel", bus.in_ready, 1'b1);
    tick();
    bus.lsu_rvalid = 1'b0;
    @(negedge clk);
    chk("rstld_state_after", bus.dbg_state, S_IDLE);
    chk("rstld_wen_after", bus.wen, 1'b0);
    chk("rstld_commit_after", bus.commit_valid, 1'b0);

    // reset during COMMIT suppresses the strobe
    tick();
    accept(32'h8000_001C, 5'd4, 1'b1, 32'h44, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rstcm_wen_pre", bus.wen, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstcm_wen", bus.wen, 1'b0);
    chk("rstcm_commit", bus.commit_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstcm_state", bus.dbg_state, S_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_23060111_wbu.md
Name: ysyx_23060111_wbu

Overview:
- Writeback unit: last stage before the register/CSR file.
- Accepts one retiring instruction at a time from EXU over a valid/ready handshake.
- For loads, waits for LSU read data; for ecall/mret, sequences the trap CSR updates and the PC redirect.
- Drives the register file's GPR write port, CSR write port and dedicated mepc/mcause/mstatus ports, one commit per instruction.

Parameters:
ADDR_WIDTH, 5, GPR index width
DATA_WIDTH, 32, datapath width

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EXU presents an instruction
in_ready  out  1  WBU can accept; high only in IDLE
in_pc  in  DATA_WIDTH  PC of instruction
in_rd  in  ADDR_WIDTH  destination GPR
in_rd_wen  in  1  instruction writes rd
in_result  in  DATA_WIDTH  ALU/CSR-read result for rd
in_is_load  in  1  rd data comes from LSU
in_csr_wen  in  1  CSR write request
in_csr_waddr  in  2  CSR index (0 mepc, 1 mcause, 2 mstatus, 3 mtvec)
in_csr_wdata  in  DATA_WIDTH  CSR write data
in_ecall  in  1  environment call
in_mret  in  1  trap return
cur_mstatus  in  DATA_WIDTH  current mstatus from register file
cur_mtvec  in  DATA_WIDTH  current mtvec
cur_mepc  in  DATA_WIDTH  current mepc
lsu_rvalid  in  1  load data valid
lsu_rdata  in  DATA_WIDTH  load data
lsu_rready  out  1  WBU accepts load data; high only in WAIT_LD
wen  out  1  GPR write strobe
waddr  out  ADDR_WIDTH  GPR index
wdata  out  DATA_WIDTH  GPR data
csr_wen  out  1  generic CSR write strobe
csr_waddr  out  2  generic CSR index
csr_wdata  out  DATA_WIDTH  generic CSR data
csr_mepc_wen  out  1  mepc write strobe
csr_mepc_wdata  out  DATA_WIDTH  mepc data
csr_mcause_wen  out  1  mcause write strobe
csr_mcause_wdata  out  DATA_WIDTH  mcause data
csrr_mstatus_wen  out  1  mstatus write strobe
csr_mstatus_wdata  out  DATA_WIDTH  mstatus data
redirect_valid  out  1  next PC is redirect_pc
redirect_pc  out  DATA_WIDTH  trap/return target
commit_valid  out  1  one-cycle retire pulse
commit_pc  out  DATA_WIDTH  PC of retired instruction

Behaviour:
- States: IDLE, WAIT_LD, COMMIT. Reset state is IDLE.
- Reset clears all captured fields to 0.
- While rst_n is low, every strobe is 0: wen, csr_wen, the three dedicated wens, redirect_valid, commit_valid, lsu_rready.
- Data outputs are 0 during reset. in_ready=0 during reset.
- IDLE: in_ready=1. On in_valid, capture all in_* fields.
  - Next state is WAIT_LD if in_is_load&&in_rd_wen, else COMMIT.
- WAIT_LD: lsu_rready=1. On lsu_rvalid, capture lsu_rdata as rd data and go to COMMIT. Wait is unbounded.
- COMMIT: lasts exactly one cycle, then IDLE. in_ready=0.
  - commit_valid=1; commit_pc=captured pc.
  - All strobes are driven combinationally from captured state, so writes land at the edge ending COMMIT.
- Latency, non-load: accept at cycle N, COMMIT at N+1, next accept at N+2. Throughput is 1 instruction per 2 cycles.
- Latency, load: COMMIT is the cycle after the lsu_rvalid handshake.
- GPR write: wen=rd_wen && rd!=0; waddr=rd. wdata = load data if load, else result. rd=0 never asserts wen.
- Generic CSR write: csr_wen=captured csr_wen && !ecall && !mret.
- ecall COMMIT (exception priority):
  - mepc_wen=1, mepc data=pc.
  - mcause_wen=1, mcause data=11.
  - mstatus_wen=1. mstatus data = cur_mstatus with [7]=cur[3], [3]=0, [12:11]=2'b11.
  - redirect_valid=1, redirect_pc=cur_mtvec.
  - Generic CSR write suppressed. GPR write still honoured if requested.
- mret COMMIT:
  - mstatus_wen=1. mstatus data = cur_mstatus with [3]=cur[7], [7]=1, [12:11]=2'b00.
  - redirect_valid=1, redirect_pc=cur_mepc.
- ecall and mret both set: ecall wins; mret ignored.
- cur_* values are sampled combinationally in COMMIT, not at accept.
- lsu_rvalid outside WAIT_LD is ignored; nothing is captured.
- in_valid outside IDLE is ignored; EXU must hold its inputs until in_ready.
- Reset mid-WAIT_LD or mid-COMMIT:
  - Returns to IDLE immediately (asynchronous).
  - No strobe is emitted and the pending instruction is dropped.
  - Later lsu_rvalid is ignored until the next load is accepted.
- Dedicated mepc/mcause/mstatus strobes assert only for ecall/mret.

Test Plan:
- ALU op rd=5, result=0x1234, in_valid at cycle 1 -> cycle 2: wen=1, waddr=5, wdata=0x1234, commit_valid=1; in_ready=1 at cycle 3.
- Load rd=10; lsu_rvalid=1 with rdata=0xDEADBEEF three cycles after accept -> lsu_rready high throughout the wait; next cycle wen=1, waddr=10, wdata=0xDEADBEEF.
- ecall pc=0x80000100, cur_mstatus=0x8, cur_mtvec=0x80000400 -> single cycle: mepc=0x80000100, mcause=11, mstatus=0x1880, redirect_pc=0x80000400; csr_wen=0.
- mret with cur_mstatus=0x1880, cur_mepc=0x80000104 -> mstatus=0x88, redirect_pc=0x80000104, no GPR write.
- rd=0 with rd_wen=1, result=0xFFFF -> commit_valid=1, wen=0. Csrw mtvec (idx 3, data 0x80000400) -> csr_wen=1, csr_waddr=3.
- Load accepted, rst_n low during WAIT_LD, then lsu_rvalid -> no wen, state IDLE, in_ready=1 after reset release.
